// File: rtl/hwpe_cfg_router.sv
// Config-bus router: steers cluster config requests to one of N_HWPE accelerator ports,
// keeps responses in order with a target FIFO, answers unmapped addresses with an error.
module hwpe_cfg_router #(
    parameter int N_HWPE     = 2,
    parameter int N_CORES    = 8,
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_LSB    = 10,
    parameter int MAX_OUTST  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_req_i,
    input  logic [ADDR_WIDTH-1:0]                    cfg_add_i,
    input  logic                                     cfg_wen_i,
    input  logic [3:0]                               cfg_be_i,
    input  logic [31:0]                              cfg_wdata_i,
    input  logic [ID_WIDTH-1:0]                      cfg_id_i,
    output logic                                     cfg_gnt_o,
    output logic                                     cfg_r_valid_o,
    output logic [31:0]                              cfg_r_rdata_o,
    output logic [ID_WIDTH-1:0]                      cfg_r_id_o,
    output logic                                     cfg_r_opc_o,
    output logic [N_HWPE-1:0]                        hwpe_req_o,
    output logic [N_HWPE-1:0][ADDR_WIDTH-1:0]        hwpe_add_o,
    output logic [N_HWPE-1:0]                        hwpe_wen_o,
    output logic [N_HWPE-1:0][3:0]                   hwpe_be_o,
    output logic [N_HWPE-1:0][31:0]                  hwpe_data_o,
    output logic [N_HWPE-1:0][ID_WIDTH-1:0]          hwpe_id_o,
    input  logic [N_HWPE-1:0]                        hwpe_gnt_i,
    input  logic [N_HWPE-1:0]                        hwpe_r_valid_i,
    input  logic [N_HWPE-1:0][31:0]                  hwpe_r_data_i,
    input  logic [N_HWPE-1:0][ID_WIDTH-1:0]          hwpe_r_id_i,
    input  logic [N_HWPE-1:0][N_CORES-1:0][1:0]      hwpe_evt_i,
    input  logic [N_HWPE-1:0]                        hwpe_busy_i,
    output logic [N_CORES-1:0][1:0]                  evt_o,
    output logic                                     busy_o
);

    localparam int SEL_W = (N_HWPE > 1) ? $clog2(N_HWPE) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [SEL_W:0] N_HWPE_W  = (SEL_W + 1)'(N_HWPE);
    localparam logic [31:0]    ERR_RDATA = 32'hBADACCE5;

    // FIFO storage: target index, error flag and (for error entries) the request id
    logic [SEL_W-1:0]    tgt_mem [MAX_OUTST];
    logic                err_mem [MAX_OUTST];
    logic [ID_WIDTH-1:0] id_mem  [MAX_OUTST];

    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [SEL_W-1:0]    tail_sel_reg;
    logic                tail_err_reg;

    logic                r_valid_reg, r_opc_reg, busy_reg;
    logic [31:0]         r_rdata_reg;
    logic [ID_WIDTH-1:0] r_id_reg;
    logic [N_CORES-1:0][1:0] evt_reg;

    logic [SEL_W-1:0]    sel;
    logic                sel_err, full, empty, same_tail, accept, tgt_gnt, push, pop;
    logic [N_HWPE-1:0]   sel_onehot;
    logic [SEL_W-1:0]    head_sel;
    logic                head_err, head_valid;
    logic [31:0]         head_rdata;
    logic [ID_WIDTH-1:0] head_rid;
    logic [N_CORES-1:0][1:0] evt_or;

    assign sel     = cfg_add_i[SEL_LSB +: SEL_W];
    assign sel_err = ({1'b0, sel} >= N_HWPE_W);
    assign full    = (count_reg == CNT_W'(MAX_OUTST));
    assign empty   = (count_reg == '0);

    // A new request may only join the tail's target, so responses can never overtake each other
    assign same_tail = (sel_err && tail_err_reg) ||
                       (!sel_err && !tail_err_reg && (sel == tail_sel_reg));
    assign accept    = !rst && !full && (empty || same_tail);

    generate
        for (genvar gi = 0; gi < N_HWPE; gi++) begin : g_port
            assign sel_onehot[gi]  = !sel_err && (sel == SEL_W'(gi));
            assign hwpe_req_o[gi]  = cfg_req_i && accept && sel_onehot[gi];
            assign hwpe_add_o[gi]  = rst ? '0 : cfg_add_i;
            assign hwpe_wen_o[gi]  = rst ? 1'b0 : cfg_wen_i;
            assign hwpe_be_o[gi]   = rst ? '0 : cfg_be_i;
            assign hwpe_data_o[gi] = rst ? '0 : cfg_wdata_i;
            assign hwpe_id_o[gi]   = rst ? '0 : cfg_id_i;
        end
    endgenerate

    assign tgt_gnt   = |(hwpe_gnt_i & sel_onehot);
    assign cfg_gnt_o = accept && (sel_err || tgt_gnt);
    assign push      = cfg_req_i && cfg_gnt_o;

    assign head_sel = tgt_mem[rd_ptr_reg];
    assign head_err = err_mem[rd_ptr_reg];

    always_comb begin
        head_valid = 1'b0;
        head_rdata = '0;
        head_rid   = '0;
        for (int i = 0; i < N_HWPE; i++) begin
            if (head_sel == SEL_W'(i)) begin
                head_valid = hwpe_r_valid_i[i];
                head_rdata = hwpe_r_data_i[i];
                head_rid   = hwpe_r_id_i[i];
            end
        end
    end

    // Error entries retire on their own; mapped entries wait for their target's response
    assign pop = !empty && (head_err || head_valid);

    always_comb begin
        evt_or = '0;
        for (int i = 0; i < N_HWPE; i++) begin
            evt_or = evt_or | hwpe_evt_i[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tgt_mem[wr_ptr_reg] <= sel;
            err_mem[wr_ptr_reg] <= sel_err;
            id_mem[wr_ptr_reg]  <= cfg_id_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tail_sel_reg <= '0;
            tail_err_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_rdata_reg  <= '0;
            r_id_reg     <= '0;
            r_opc_reg    <= 1'b0;
            evt_reg      <= '0;
            busy_reg     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg   <= (wr_ptr_reg == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
                tail_sel_reg <= sel;
                tail_err_reg <= sel_err;
            end
            if (pop) begin
                rd_ptr_reg  <= (rd_ptr_reg == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
                r_rdata_reg <= head_err ? ERR_RDATA : head_rdata;
                r_id_reg    <= head_err ? id_mem[rd_ptr_reg] : head_rid;
                r_opc_reg   <= head_err;
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
            r_valid_reg <= pop;
            evt_reg     <= evt_or;
            busy_reg    <= |hwpe_busy_i;
        end
    end

    assign cfg_r_valid_o = r_valid_reg;
    assign cfg_r_rdata_o = r_rdata_reg;
    assign cfg_r_id_o    = r_id_reg;
    assign cfg_r_opc_o   = r_opc_reg;
    assign evt_o         = evt_reg;
    assign busy_o        = busy_reg;

endmodule
